// File: rtl/alu_operation_unit.sv
// EX-stage execution unit: one-cycle logic/add/sub/pass, iterative shift-add MUL,
// valid/ready handshakes on both sides and registered result plus NZCV flags.
module alu_operation_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             IllegalOp,
  output logic             busy
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc, mcand, mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   alu_res, b_op, mul_sum;
  logic [WIDTH:0]     sum;
  logic               alu_c, alu_v, alu_ill, is_sub, last_iter;

  // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    is_sub  = (Operation == OP_SUB);
    b_op    = is_sub ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    case (Operation)
      OP_AND:   alu_res = A & B;
      OP_ORR:   alu_res = A | B;
      OP_PASSB: alu_res = B;
      OP_NOR:   alu_res = ~(A | B);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:   alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end

  assign mul_sum   = mplier[0] ? acc + mcand : acc;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = (Operation == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (last_iter) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: the multiply registers are reset too, so an aborted MUL leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      Result    <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          if (Operation == OP_MUL) begin
            acc    <= '0;
            mcand  <= A;
            mplier <= B;
            cnt    <= '0;
          end else begin
            Result    <= alu_res;
            Zero      <= (alu_res == '0);
            Negative  <= alu_res[WIDTH-1];
            Carry     <= alu_c;
            Overflow  <= alu_v;
            IllegalOp <= alu_ill;
          end
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            Result    <= mul_sum;
            Zero      <= (mul_sum == '0);
            Negative  <= mul_sum[WIDTH-1];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            IllegalOp <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/alu_operation_unit.md
# alu_operation_unit

Handshaked, registered execution unit that consumes the 4-bit `Operation` code produced by the ALU control decoder, together with two operands, and returns a result plus NZCV flags. It sits in the EX stage of the ARM CPU, downstream of ALU control. Single-cycle codes complete in one clock; the MUL code runs an iterative shift-add multiply. A valid/ready pair on each side lets a multi-cycle core stall on it.

## Interface
- `WIDTH`, default 64: operand and result width in bits (≥ 8).
- `CNT_W`, default 7: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: unit can accept a request.
- `Operation` input, 4 bits: operation code.
- `A` input, `WIDTH` bits: operand A, also the multiplicand.
- `B` input, `WIDTH` bits: operand B, also the multiplier.
- `out_valid` output, 1 bit: result and flags valid.
- `out_ready` input, 1 bit: consumer takes the result.
- `Result` output, `WIDTH` bits: registered result.
- `Zero`, `Negative`, `Carry`, `Overflow` outputs, 1 bit each: registered flags.
- `IllegalOp` output, 1 bit: the completed request carried an undefined code.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Codes:
  - 0000 AND
  - 0001 ORR
  - 0010 ADD
  - 0110 SUB
  - 0111 PASSB (Result = B)
  - 1100 NOR
  - 1000 MUL (low `WIDTH` bits of A×B, unsigned)
  - Any other code: Result = 0, IllegalOp = 1, Zero = 1, N = C = V = 0.
- State machine: IDLE, MUL, DONE.
  - IDLE: `in_ready` = 1. On `in_valid`, the request is captured.
    - MUL → go to MUL; load acc = 0, mcand = A, mplier = B, cnt = 0.
    - Any other code → compute combinationally, register Result and flags, go to DONE.
  - MUL: each cycle, if mplier[0] then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++. After the iteration with cnt = WIDTH−1, register Result = acc (including that final add) and go to DONE.
  - DONE: `out_valid` = 1 and outputs are held stable. On `out_ready` go to IDLE.
- Arithmetic (all results truncated to `WIDTH` bits):
  - ADD: {Carry, Result} = A + B.
  - SUB: {Carry, Result} = A + ~B + 1, so Carry = 1 means no borrow.
  - Overflow is the signed overflow of that add: operand MSBs equal and result MSB different.
  - Logic, PASSB, MUL: Carry = Overflow = 0.
  - Zero = (Result == 0) and Negative = Result[WIDTH−1] for every code.
- Operands and code are sampled only at acceptance. Later input changes have no effect on an in-flight operation.
- `in_ready` is low in MUL and DONE, so there is at most one operation in flight.

## Timing
- Reset (asynchronous, any state, including mid-MUL): state = IDLE, `in_ready` = 1, and every other output is 0. The in-flight operation is discarded and acc, cnt, mcand and mplier are cleared.
- Release of `rst_n` is synchronous to `clk`. The first acceptance can happen on the first rising edge after deassertion.
- Let E0 be the acceptance edge (IDLE with `in_valid` high).
  - Non-MUL codes: `out_valid` rises after E0, a latency of 1 cycle.
  - MUL: `out_valid` rises after edge E0+WIDTH, a latency of WIDTH+1 cycles.
- DONE with `out_ready` already high: one cycle of `out_valid`, then IDLE.
- Maximum throughput is one non-MUL operation every 2 cycles. A request asserted during DONE is not accepted until the cycle after the state returns to IDLE.
- `out_valid` and the output values never change while `out_valid` = 1 and `out_ready` = 0. Backpressure may last indefinitely.
- `in_valid` is ignored while `in_ready` = 0. The producer must hold the request until accepted.
- Result, flags and IllegalOp keep their last values after leaving DONE until the next completion overwrites them.

## Test plan
- Reset and ADD: drop `rst_n` mid-cycle → all outputs 0 immediately and `in_ready` = 1. Then ADD A = 0xFFFF_FFFF_FFFF_FFFF, B = 1 → one cycle later Result = 0, Z = 1, C = 1, V = 0, N = 0.
- SUB overflow and borrow:
  - SUB A = 0x8000_0000_0000_0000, B = 1 → Result = 0x7FFF_FFFF_FFFF_FFFF, V = 1, C = 1, N = 0.
  - SUB A = 3, B = 5 → Result = 0xFFFF_FFFF_FFFF_FFFE, N = 1, C = 0, V = 0.
- Logic and undefined codes:
  - AND/ORR/NOR/PASSB on A = 0xF0F0, B = 0x0FF0 → Results 0x00F0, 0xFFF0, 0xFFFF_FFFF_FFFF_000F, 0x0FF0.
  - Code 0101 → Result = 0, IllegalOp = 1, Z = 1.
- MUL: A = 123456789, B = 987654321 → `out_valid` exactly 65 cycles after acceptance, Result = 121932631112635269, C = V = 0. Toggle A and B during MUL → no change to the result.
- Backpressure: hold `out_ready` = 0 for 10 cycles with `in_valid` high → outputs stable, `in_ready` = 0, no second acceptance. Release → DONE to IDLE, then the next request is accepted on the following edge.
- Reset mid-MUL: assert `rst_n` = 0 at iteration 30 → immediate IDLE. A new ADD 2+2 then gives Result = 4 after 1 cycle, with no trace of the aborted multiply.
